// File: rtl/mem_burst_sequencer_if.sv
// ----------------------------------------------------------------------------
// mem_burst_sequencer_if: request, memory-read and output-stream bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_burst_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_base;
  logic [7:0]            req_len;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  // master: requester, memory read stage and stream consumer
  modport master (
    output req_valid, req_base, req_len, mem_data, out_ready,
    input  req_ready, req_err, mem_addr, out_valid, out_data, out_last
  );

  // slave: the burst sequencer itself
  modport slave (
    input  req_valid, req_base, req_len, mem_data, out_ready,
    output req_ready, req_err, mem_addr, out_valid, out_data, out_last
  );
endinterface

`default_nettype wire

// File: rtl/mem_burst_sequencer.sv
// ----------------------------------------------------------------------------
// mem_burst_sequencer: credit-limited burst reader feeding a FWFT output FIFO.
// Option MEM_BURST_SEQUENCER_STATS_EN adds the rd_count pop counter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_burst_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input wire clk,
  input wire reset,
  mem_burst_sequencer_if.slave bus
`ifdef MEM_BURST_SEQUENCER_STATS_EN
  ,
  output logic [31:0] rd_count
`endif
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] c_PARK      = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] c_DEPTH     = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0]    c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT1 = 2'd2,
    WAIT2 = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [7:0]            r_remaining;
  logic                  r_req_err;
  logic [ADDR_WIDTH-1:0] w_mem_addr;

  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_base_ok;
  logic [c_CNT_W-1:0]    w_inflight;
  logic                  w_credit;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_valid;

  assign w_req_ready = (r_state == IDLE) && !reset;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_base_ok   = (bus.req_base < c_DEPTH);

  // A read is in flight from the cycle after issue until its WAIT2 push.
  assign w_inflight  = {{(c_CNT_W-1){1'b0}}, (r_state == WAIT1) || (r_state == WAIT2)};
  assign w_credit    = (r_count + w_inflight) < c_FIFO_FULL;

  assign w_out_valid = (r_count != '0);
  assign w_push      = (r_state == WAIT2);
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_addr  = c_PARK;
    case (r_state)
      IDLE: begin
        if (w_accept && w_base_ok) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (w_credit && !reset) begin
          w_mem_addr  = r_cur_addr;
          w_state_nxt = WAIT1;
        end
      end
      WAIT1: begin
        w_state_nxt = WAIT2;
      end
      WAIT2: begin
        w_state_nxt = (r_remaining == 8'd0) ? IDLE : ISSUE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_req_err   <= 1'b0;
    end else begin
      r_req_err <= w_accept && !w_base_ok;
      if (w_accept && w_base_ok) begin
        r_cur_addr  <= bus.req_base;
        r_remaining <= bus.req_len;
      end else if (w_push && (r_remaining != 8'd0)) begin
        r_remaining <= r_remaining - 8'd1;
        r_cur_addr  <= (r_cur_addr == c_LAST_ADDR) ? '0 : r_cur_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Storage needs no reset: the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.mem_data;
      r_fifo_last[r_wr_ptr] <= (r_remaining == 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.req_err   = r_req_err;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.out_last  = w_out_valid ? r_fifo_last[r_rd_ptr] : 1'b0;

`ifdef MEM_BURST_SEQUENCER_STATS_EN
  logic [31:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_count <= '0;
    end else if (w_pop) begin
      r_rd_count <= r_rd_count + 32'd1;
    end
  end

  assign rd_count = r_rd_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mem_burst_sequencer: directed bench with a 2-cycle memory model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_burst_sequencer;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam int FD    = 4;
  localparam logic [AW-1:0] PARK = 16'hFFFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mem_burst_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

`ifdef MEM_BURST_SEQUENCER_STATS_EN
  logic [31:0] rd_count;
`endif

  mem_burst_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
`ifdef MEM_BURST_SEQUENCER_STATS_EN
    ,
    .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] data_of(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Memory read stage: address registered, data registered -> 2-cycle latency
  logic [AW-1:0] mem_s1 = PARK;
  logic [DW-1:0] mem_s2 = '0;
  always @(posedge clk) begin
    mem_s1 <= bus_if.mem_addr;
    mem_s2 <= data_of(mem_s1);
  end
  assign bus_if.mem_data = mem_s2;

  int            cyc = 0;
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  logic [AW-1:0] iss_addr [$];
  int            iss_cyc  [$];
  int            err_cnt   = 0;
  int            valid_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.out_valid && bus_if.out_ready) begin
        got_data.push_back(bus_if.out_data);
        got_last.push_back(bus_if.out_last);
      end
      if (bus_if.out_valid) valid_cnt++;
      if (bus_if.req_err) err_cnt++;
      if (bus_if.mem_addr != PARK) begin
        iss_addr.push_back(bus_if.mem_addr);
        iss_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_req(input logic [AW-1:0] base, input logic [7:0] len);
    int n = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_base  = base;
    bus_if.req_len   = len;
    @(negedge clk);
    while (!bus_if.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_value("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_words(input int start, input int n, input int budget);
    int k = 0;
    while (got_data.size() < start + n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (k >= budget) check_value("word_wait_timeout", got_data.size() - start, n);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input string tag, input int s, input int si,
                             input logic [AW-1:0] exp[$], input bit chk_gap);
    check_value({tag, "_words"}, got_data.size() - s, exp.size());
    check_value({tag, "_issues"}, iss_addr.size() - si, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check_value($sformatf("%s_data%0d", tag, i), got_data[s+i], data_of(exp[i]));
      check_value($sformatf("%s_last%0d", tag, i), got_last[s+i], (i == exp.size() - 1));
      check_value($sformatf("%s_addr%0d", tag, i), iss_addr[si+i], exp[i]);
      if (chk_gap && i > 0)
        check_value($sformatf("%s_gap%0d", tag, i), iss_cyc[si+i] - iss_cyc[si+i-1], 3);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp [$];
    int s, si, s2, si2, v0, v2, e0, n;

    bus_if.req_valid = 1'b0;
    bus_if.req_base  = '0;
    bus_if.req_len   = '0;
    bus_if.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check_value("rst_req_ready_in_reset", bus_if.req_ready, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_value("rst_mem_addr", bus_if.mem_addr, PARK);
    check_value("rst_out_valid", bus_if.out_valid, 1'b0);
    check_value("rst_out_data", bus_if.out_data, 8'h00);
    check_value("rst_out_last", bus_if.out_last, 1'b0);
    check_value("rst_req_err", bus_if.req_err, 1'b0);
    check_value("rst_req_ready_after", bus_if.req_ready, 1'b1);
    @(posedge clk);
    #1;

    // base=5 len=3, free-running consumer
    s = got_data.size(); si = iss_addr.size();
    send_req(16'd5, 8'd3);
    wait_words(s, 4, 80);
    exp = {16'd5, 16'd6, 16'd7, 16'd8};
    check_burst("t1", s, si, exp, 1'b1);

    // Address wrap at DEPTH-1
    s = got_data.size(); si = iss_addr.size();
    send_req(16'd1022, 8'd3);
    wait_words(s, 4, 80);
    exp = {16'd1022, 16'd1023, 16'd0, 16'd1};
    check_burst("t2", s, si, exp, 1'b1);

    // Out-of-range base is rejected
    s = got_data.size(); si = iss_addr.size(); e0 = err_cnt; v0 = valid_cnt;
    send_req(16'd1024, 8'd0);
    @(negedge clk);
    check_value("t3_req_err_pulse", bus_if.req_err, 1'b1);
    check_value("t3_req_ready_next", bus_if.req_ready, 1'b1);
    @(negedge clk);
    check_value("t3_req_err_drop", bus_if.req_err, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_value("t3_err_cycles", err_cnt - e0, 1);
    check_value("t3_no_valid", valid_cnt - v0, 0);
    check_value("t3_no_issue", iss_addr.size() - si, 0);
    check_value("t3_no_words", got_data.size() - s, 0);

    // Back-pressure: FIFO fills after 4 reads, then drains losslessly
    bus_if.out_ready = 1'b0;
    s = got_data.size(); si = iss_addr.size();
    send_req(16'd100, 8'd9);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_value("t4_issues_full", iss_addr.size() - si, 4);
    check_value("t4_valid_full", bus_if.out_valid, 1'b1);
    check_value("t4_head_data", bus_if.out_data, data_of(16'd100));
    check_value("t4_head_last", bus_if.out_last, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_value("t4_issues_stalled", iss_addr.size() - si, 4);
    @(posedge clk);
    #1 bus_if.out_ready = 1'b1;
    wait_words(s, 10, 200);
    exp.delete();
    for (int i = 0; i < 10; i++) exp.push_back(16'(100 + i));
    check_burst("t4", s, si, exp, 1'b0);

    // Reset two cycles after the second issue of a len=7 burst
    bus_if.out_ready = 1'b0;
    s = got_data.size(); si = iss_addr.size();
    send_req(16'd200, 8'd7);
    n = 0;
    while (iss_addr.size() - si < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_value("t5_second_issue", iss_addr.size() - si, 2);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_value("t5_buffered_before", bus_if.out_valid, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check_value("t5_out_valid_after", bus_if.out_valid, 1'b0);
    check_value("t5_mem_addr_after", bus_if.mem_addr, PARK);
    s2 = got_data.size(); si2 = iss_addr.size(); v2 = valid_cnt;
    repeat (25) @(posedge clk);
    #1;
    check_value("t5_no_stale_words", got_data.size() - s2, 0);
    check_value("t5_no_stale_valid", valid_cnt - v2, 0);
    check_value("t5_no_issue", iss_addr.size() - si2, 0);
    send_req(16'd0, 8'd0);
    wait_words(s2, 1, 40);
    exp = {16'd0};
    check_burst("t5r", s2, si2, exp, 1'b0);

`ifdef MEM_BURST_SEQUENCER_STATS_EN
    // Pop counter over two bursts of 4 and 2 words
    do_reset();
    @(negedge clk);
    check_value("t6_rd_count_reset", rd_count, 32'd0);
    @(posedge clk);
    #1;
    s = got_data.size();
    send_req(16'd40, 8'd3);
    wait_words(s, 4, 80);
    s = got_data.size();
    send_req(16'd50, 8'd1);
    wait_words(s, 2, 80);
    check_value("t6_rd_count", rd_count, 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_burst_sequencer.md
MEM_BURST_SEQUENCER -- requirements
Module: mem_burst_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, the width of the memory word and the output stream data.
REQ-002 Parameter ADDR_WIDTH, default 16, the width of the memory address; 2**ADDR_WIDTH SHALL exceed DEPTH.
REQ-003 Parameter DEPTH, default 1024, the number of memory words; valid addresses are 0..DEPTH-1.
REQ-004 Parameter FIFO_DEPTH, default 4, the number of output buffer entries; it SHALL be a power of 2 and at least 2.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req_valid, input, 1 bit: a burst request is present.
REQ-008 Port req_ready, output, 1 bit: the block accepts a burst request this cycle.
REQ-009 Port req_base, input, ADDR_WIDTH bits: the first word address of the burst.
REQ-010 Port req_len, input, 8 bits: the burst length minus 1 (1..256 words).
REQ-011 Port req_err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-012 Port mem_addr, output, ADDR_WIDTH bits: the address driven to the downstream memory read stage.
REQ-013 Port mem_data, input, DATA_WIDTH bits: the read data returned by the memory read stage.
REQ-014 Port out_valid, output, 1 bit: out_data holds a valid word.
REQ-015 Port out_ready, input, 1 bit: the consumer accepts the word.
REQ-016 Port out_data, output, DATA_WIDTH bits: the buffered read word.
REQ-017 Port out_last, output, 1 bit: marks the final word of a burst.

Function
REQ-018 The block SHALL use an FSM with states IDLE, ISSUE, WAIT1 and WAIT2.
REQ-019 When idle, mem_addr SHALL be held at PARK = {ADDR_WIDTH{1'b1}}, which is at or above DEPTH, so the memory stage starts no read.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when both req_valid and req_ready are 1.
REQ-021 If the accepted req_base is at or above DEPTH, the block SHALL pulse req_err for one cycle, stay in IDLE and produce no output words.
REQ-022 A valid request SHALL load cur_addr=req_base and remaining=req_len, then move to ISSUE.
REQ-023 In ISSUE, when credit is available, the block SHALL drive mem_addr=cur_addr for exactly one cycle and then move to WAIT1; credit is available when FIFO occupancy plus in-flight reads is less than FIFO_DEPTH.
REQ-024 In ISSUE without credit, mem_addr SHALL stay at PARK and the block SHALL remain in ISSUE.
REQ-025 From WAIT1 the block SHALL move to WAIT2, with mem_addr at PARK.
REQ-026 In WAIT2, mem_data SHALL be written into the FIFO, which fixes read latency at 2 cycles after the issue cycle; out_last SHALL be 1 for that entry when remaining==0.
REQ-027 From WAIT2, the block SHALL return to IDLE if remaining==0; otherwise it SHALL decrement remaining, advance cur_addr, and move to ISSUE.
REQ-028 Address advance SHALL wrap: cur_addr = (cur_addr==DEPTH-1) ? 0 : cur_addr+1.
REQ-029 The maximum issue rate SHALL be one read every 3 cycles.
REQ-030 The output FIFO SHALL be first-word-fall-through: out_valid=1 whenever it is non-empty, and an entry pops when out_valid and out_ready are both 1.
REQ-031 A simultaneous push and pop SHALL leave occupancy unchanged, including when the FIFO is full; the credit rule guarantees no overflow.
REQ-032 A pop from an empty FIFO SHALL have no effect.
REQ-033 A new request SHALL be accepted in IDLE even while earlier burst words are still buffered.

Reset
REQ-034 On reset: state=IDLE, mem_addr=PARK, FIFO empty, out_valid=0, out_data=0, out_last=0, req_ready=0 during the reset cycle, req_err=0.
REQ-035 Reset asserted mid-burst SHALL discard all buffered and in-flight data; no word SHALL appear on out_valid until a new request is accepted.

Configuration
REQ-036 With MEM_BURST_SEQUENCER_STATS_EN defined, the block SHALL add the output port rd_count (32 bits), which counts words popped on the output, wraps at 2**32, and resets to 0.
REQ-037 Without MEM_BURST_SEQUENCER_STATS_EN defined, the port rd_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 The bench SHALL cover: base=5, len=3, out_ready=1 -> words from addresses 5,6,7,8 in order; out_last only on the 8 word; mem_addr non-PARK for one cycle every 3 cycles.
REQ-039 The bench SHALL cover: base=1022, len=3, DEPTH=1024 -> addresses 1022,1023,0,1.
REQ-040 The bench SHALL cover: base=1024 -> req_err pulses for 1 cycle, no out_valid, and req_ready=1 on the next cycle.
REQ-041 The bench SHALL cover: len=9, out_ready=0 -> issues stop after 4 reads with the FIFO full; after out_ready=1 all 10 words arrive without loss or duplication.
REQ-042 The bench SHALL cover: reset asserted 2 cycles after the second issue of a len=7 burst -> FIFO empty, mem_addr=PARK the next cycle, no stale words afterwards.
REQ-043 The bench SHALL cover: with STATS_EN defined, two bursts of lengths 4 and 2 (req_len 3 and 1) fully drained -> rd_count=6.
